// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial NUM_BITS-wide adder. Operands are captured in parallel on an
//   accepted start, shifted LSB-first through a single adder_1bit cell over
//   NUM_BITS cycles, and the assembled result is registered on completion.
//   The cell's carry_out is registered in c_reg and fed back as the next
//   bit's carry_in.
//
//   Optional build macro: SERIAL_ADD_SIGNED_EN
//     defined   -> overflow is the two's-complement overflow
//                  (carry into MSB XOR carry out of MSB)
//     undefined -> overflow is the unsigned carry out of the MSB
//
// Ports
//   clk       in  1         rising-edge clock
//   n_rst     in  1         asynchronous active-low reset
//   start     in  1         request, sampled only in IDLE
//   a, b      in  NUM_BITS  operands, captured on the accepted start edge
//   carry_in  in  1         initial carry, captured with a/b
//   sum       out NUM_BITS  registered result, held until the next completion
//   overflow  out 1         registered overflow flag
//   busy      out 1         high in RUN and DONE
//   done      out 1         one-cycle completion pulse
// ---------------------------------------------------------------------------

// Single full-adder cell
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [NUM_BITS-1:0] a_sh;
  logic [NUM_BITS-1:0] b_sh;
  logic [NUM_BITS-1:0] sum_sh;
  logic                c_reg;
  logic [CNT_W-1:0]    cnt;

  logic cell_sum;
  logic cell_co;
  logic load_c;
  logic shift_c;
  logic last_bit_c;
  logic ovf_c;
  logic busy_nxt;
  logic done_nxt;

  // The single shared full-adder cell
  adder_1bit u_cell (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .carry_in (c_reg),
    .sum      (cell_sum),
    .carry_out(cell_co)
  );

  assign last_bit_c = (state == RUN) && (cnt == CNT_W'(NUM_BITS - 1));

  // Before the final RUN edge c_reg holds the carry into the MSB
`ifdef SERIAL_ADD_SIGNED_EN
  assign ovf_c = c_reg ^ cell_co;
`else
  assign ovf_c = cell_co;
`endif

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit_c) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath control decode; busy and done are registered from next_state
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state == IDLE && start) load_c = 1'b1;
    if (state == RUN) shift_c = 1'b1;
    if (next_state != IDLE) busy_nxt = 1'b1;
    if (next_state == DONE) done_nxt = 1'b1;
  end

  // Operand shifters, carry feedback and bit counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
    end else if (load_c) begin
      a_sh  <= a;
      b_sh  <= b;
      c_reg <= carry_in;
      cnt   <= '0;
    end else if (shift_c) begin
      a_sh   <= {1'b0, a_sh[NUM_BITS-1:1]};
      b_sh   <= {1'b0, b_sh[NUM_BITS-1:1]};
      sum_sh <= {cell_sum, sum_sh[NUM_BITS-1:1]};
      c_reg  <= cell_co;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers, written only on the RUN->DONE edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else if (last_bit_c) begin
      sum      <= {cell_sum, sum_sh[NUM_BITS-1:1]};
      overflow <= ovf_c;
    end
  end

  // Handshake registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

`ifndef SYNTHESIS
  // Flag unknown operands on an accepted start
  always @(posedge clk) begin
    if (n_rst && state == IDLE && start && $isunknown({a, b, carry_in}))
      $error("serial_adder_ctrl: X/Z on a, b or carry_in at accepted start");
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed bench for serial_adder_ctrl (NUM_BITS=8). A cycle-level
//   transaction model predicts busy/done/sum/overflow from plain arithmetic
//   and a compare process checks them every falling edge; directed scenarios
//   add literal expectations for sums, flags, latency and pulse counts.
//   Define SERIAL_ADD_SIGNED_EN for both RTL and bench to check the signed build.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic [N-1:0] sum;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;

  serial_adder_ctrl #(.NUM_BITS(N)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .carry_in(carry_in),
    .sum     (sum),
    .overflow(overflow),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  int           cyc = 0;
  int           acc = 0;
  bit           active = 1'b0;
  logic [N-1:0] p_sum;
  logic         p_ov;
  logic [N-1:0] m_sum = '0;
  logic         m_ov = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    logic [N:0] full;
    if (!n_rst) begin
      cyc = 0; active = 1'b0;
      m_sum = '0; m_ov = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      cyc++;
      if (active) begin
        if (cyc == acc + N) begin
          m_sum = p_sum; m_ov = p_ov; m_done = 1'b1;
        end else if (cyc == acc + N + 1) begin
          m_done = 1'b0; m_busy = 1'b0; active = 1'b0;
        end
      end else if (start) begin
        acc = cyc; active = 1'b1; m_busy = 1'b1;
        full  = {1'b0, a} + {1'b0, b} + (N+1)'(carry_in);
        p_sum = full[N-1:0];
`ifdef SERIAL_ADD_SIGNED_EN
        p_ov  = (a[N-1] == b[N-1]) && (p_sum[N-1] != a[N-1]);
`else
        p_ov  = full[N];
`endif
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (n_rst) begin
      chk("busy",     32'(busy),     32'(m_busy));
      chk("done",     32'(done),     32'(m_done));
      chk("sum",      32'(sum),      32'(m_sum));
      chk("overflow", 32'(overflow), 32'(m_ov));
    end
  end

  // ---------------- directed scenarios ----------------
  int k_done, busy_cnt, done_cnt;

  // Called at a falling edge; start is sampled on the next rising edge.
  // repulse_k > 0 re-asserts start with a different a at that RUN cycle.
  // rst_k > 0 asserts n_rst mid-operation at that cycle and returns.
  task automatic run_add(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                         input int repulse_k, input int rst_k);
    a = ia; b = ib; carry_in = ic; start = 1'b1;
    k_done = 0; busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom); b = N'($urandom);
      if (k == repulse_k) begin
        start = 1'b1; a = 8'hF0;
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (k_done == 0) k_done = k; end
      if (k == rst_k) begin
        #2 n_rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);
        return;
      end
      if (!busy) return;
    end
    chk("busy_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // 1: latency and busy length
    run_add(8'h0F, 8'h01, 1'b0, 0, 0);
    chk("t1_sum", 32'(sum), 32'h10);
    chk("t1_ovf", 32'(overflow), 32'd0);
    chk("t1_done_latency", 32'(k_done - 1), 32'd8);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);

    // 2: unsigned wrap
    run_add(8'hFF, 8'h01, 1'b0, 0, 0);
    chk("t2_sum", 32'(sum), 32'h00);
`ifdef SERIAL_ADD_SIGNED_EN
    chk("t2_ovf", 32'(overflow), 32'd0);
`else
    chk("t2_ovf", 32'(overflow), 32'd1);
`endif

    // 3: signed overflow boundary
    run_add(8'h7F, 8'h01, 1'b0, 0, 0);
    chk("t3_sum", 32'(sum), 32'h80);
`ifdef SERIAL_ADD_SIGNED_EN
    chk("t3_ovf", 32'(overflow), 32'd1);
`else
    chk("t3_ovf", 32'(overflow), 32'd0);
`endif

    // 4: carry-in only, then full carry ripple
    run_add(8'h00, 8'h00, 1'b1, 0, 0);
    chk("t4a_sum", 32'(sum), 32'h01);
    chk("t4a_ovf", 32'(overflow), 32'd0);
    run_add(8'hAA, 8'h55, 1'b1, 0, 0);
    chk("t4b_sum", 32'(sum), 32'h00);
`ifdef SERIAL_ADD_SIGNED_EN
    chk("t4b_ovf", 32'(overflow), 32'd0);
`else
    chk("t4b_ovf", 32'(overflow), 32'd1);
`endif

    // 5: start during RUN ignored; back-to-back start after done accepted
    run_add(8'h03, 8'h04, 1'b0, 3, 0);
    chk("t5_sum", 32'(sum), 32'h07);
    chk("t5_done_pulses", 32'(done_cnt), 32'd1);
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd9);
    run_add(8'h20, 8'h22, 1'b0, 0, 0);
    chk("t5b_sum", 32'(sum), 32'h42);
    chk("t5b_done_latency", 32'(k_done - 1), 32'd8);

    // 6: async reset mid-RUN, then recovery
    run_add(8'h55, 8'h11, 1'b0, 0, 4);
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    run_add(8'h12, 8'h34, 1'b0, 0, 0);
    chk("t6_sum", 32'(sum), 32'h46);
    chk("t6_ovf", 32'(overflow), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
